// File: rtl/ce_ls_mult_mc.sv
// Multi-channel LS channel estimator: per-beat complex multiply by a shared RS-TX coefficient
// (conjugate or plain), round half-up, scale by 2^-SHIFT and saturate, with frame-length checking.
module ce_ls_mult_mc #(
    parameter int wDataIn  = 16,
    parameter int wCoeff   = 18,
    parameter int wDataOut = 16,
    parameter int nChan    = 2,
    parameter int SHIFT    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n_sync,
    input  logic                        sink_valid,
    output logic                        sink_ready,
    input  logic                        sink_sop,
    input  logic                        sink_eop,
    input  logic [nChan*wDataIn-1:0]    sink_real,
    input  logic [nChan*wDataIn-1:0]    sink_imag,
    input  logic [wCoeff-1:0]           coef_real,
    input  logic [wCoeff-1:0]           coef_imag,
    input  logic [1:0]                  mode,
    input  logic [11:0]                 fftpts_in,
    output logic                        source_valid,
    input  logic                        source_ready,
    output logic                        source_sop,
    output logic                        source_eop,
    output logic [nChan*wDataOut-1:0]   source_real,
    output logic [nChan*wDataOut-1:0]   source_imag,
    output logic [1:0]                  source_error,
    output logic                        source_sat,
    output logic [11:0]                 fftpts_out,
    output logic                        dbg_state
);
    localparam int WP = wDataIn + wCoeff;
    localparam int WR = WP + 2;
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_INFRAME = 1'b1;
    localparam longint MAXL = (longint'(1) << (wDataOut - 1)) - 1;
    localparam logic signed [WR-1:0] MAX_V = WR'(MAXL);
    localparam logic signed [WR-1:0] MIN_V = WR'(-MAXL - 1);
    localparam logic signed [WR-1:0] RND_V = WR'(longint'(1) << (SHIFT - 1));

    // Handshake: a beat moves on a cycle where valid & ready; every stage advances together
    // when the output register is empty or being drained, so sink_ready equals that enable.
    logic en, acc;
    logic [0:0] state_q, state_d;
    logic [11:0] cnt_q, cnt_d, fft_q, fft_d;
    logic [1:0] mode_q, mode_d, err_in;

    logic v1_q, sop1_q, eop1_q;
    logic [1:0] err1_q, mode1_q;
    logic [nChan*wDataIn-1:0] re1_q, im1_q;
    logic [wCoeff-1:0] c1_q, d1_q;

    logic v2_q, sop2_q, eop2_q;
    logic [1:0] err2_q, mode2_q;
    logic signed [WP-1:0] ac_q[nChan], bd_q[nChan], bc_q[nChan], ad_q[nChan];
    logic signed [WP-1:0] ac_d[nChan], bd_d[nChan], bc_d[nChan], ad_d[nChan];
    logic signed [wDataIn-1:0] a2_q[nChan], b2_q[nChan];

    logic src_valid_q, src_sop_q, src_eop_q, src_sat_q, sat_d;
    logic [1:0] src_err_q;
    logic [nChan*wDataOut-1:0] src_re_q, src_im_q, out_re_d, out_im_d;

    assign en         = !src_valid_q || source_ready;
    assign acc        = sink_valid && en;
    assign sink_ready = en;

    function automatic logic [wDataOut:0] sat_fn(input logic signed [WR-1:0] v);
        if (v > MAX_V) return {1'b1, MAX_V[wDataOut-1:0]};
        if (v < MIN_V) return {1'b1, MIN_V[wDataOut-1:0]};
        return {1'b0, v[wDataOut-1:0]};
    endfunction

    // Mode/fftpts are taken from the sop beat itself, so the sop beat already uses the new mode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fft_d   = fft_q;
        err_in  = 2'b00;
        if (acc) begin
            if (sink_sop) begin
                mode_d = mode;
                fft_d  = fftpts_in;
                cnt_d  = 12'd1;
                if (state_q == ST_INFRAME) err_in[1] = 1'b1;
                if (sink_eop) begin
                    state_d = ST_IDLE;
                    if (fftpts_in != 12'd1) err_in[1] = 1'b1;
                end else begin
                    state_d = ST_INFRAME;
                end
            end else if (state_q == ST_IDLE) begin
                err_in[0] = 1'b1;
            end else begin
                cnt_d = cnt_q + 12'd1;
                if (sink_eop) begin
                    state_d = ST_IDLE;
                    if (cnt_q + 12'd1 != fft_q) err_in[1] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fft_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fft_q   <= fft_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        for (int k = 0; k < nChan; k++) begin
            ac_d[k] = WP'($signed(re1_q[k*wDataIn +: wDataIn])) * WP'($signed(c1_q));
            bd_d[k] = WP'($signed(im1_q[k*wDataIn +: wDataIn])) * WP'($signed(d1_q));
            bc_d[k] = WP'($signed(im1_q[k*wDataIn +: wDataIn])) * WP'($signed(c1_q));
            ad_d[k] = WP'($signed(re1_q[k*wDataIn +: wDataIn])) * WP'($signed(d1_q));
        end
    end

    always_comb begin
        logic signed [WR-1:0] sre, sim, tre, tim;
        logic [wDataOut:0] rre, rim;
        out_re_d = '0;
        out_im_d = '0;
        sat_d    = 1'b0;
        for (int k = 0; k < nChan; k++) begin
            if (mode2_q == 2'b00) begin
                sre = WR'(ac_q[k]) + WR'(bd_q[k]);
                sim = WR'(bc_q[k]) - WR'(ad_q[k]);
            end else begin
                sre = WR'(ac_q[k]) - WR'(bd_q[k]);
                sim = WR'(ad_q[k]) + WR'(bc_q[k]);
            end
            if (mode2_q[1]) begin
                tre = WR'(a2_q[k]);
                tim = WR'(b2_q[k]);
            end else begin
                tre = (sre + RND_V) >>> SHIFT;
                tim = (sim + RND_V) >>> SHIFT;
            end
            rre = sat_fn(tre);
            rim = sat_fn(tim);
            out_re_d[k*wDataOut +: wDataOut] = rre[wDataOut-1:0];
            out_im_d[k*wDataOut +: wDataOut] = rim[wDataOut-1:0];
            sat_d = sat_d | rre[wDataOut] | rim[wDataOut];
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            v1_q <= 1'b0; sop1_q <= 1'b0; eop1_q <= 1'b0; err1_q <= '0; mode1_q <= '0;
            re1_q <= '0; im1_q <= '0; c1_q <= '0; d1_q <= '0;
            v2_q <= 1'b0; sop2_q <= 1'b0; eop2_q <= 1'b0; err2_q <= '0; mode2_q <= '0;
            for (int k = 0; k < nChan; k++) begin
                ac_q[k] <= '0; bd_q[k] <= '0; bc_q[k] <= '0; ad_q[k] <= '0;
                a2_q[k] <= '0; b2_q[k] <= '0;
            end
            src_valid_q <= 1'b0; src_sop_q <= 1'b0; src_eop_q <= 1'b0;
            src_err_q <= '0; src_sat_q <= 1'b0; src_re_q <= '0; src_im_q <= '0;
        end else if (en) begin
            v1_q <= sink_valid; sop1_q <= sink_sop; eop1_q <= sink_eop;
            err1_q <= err_in; mode1_q <= mode_d;
            re1_q <= sink_real; im1_q <= sink_imag; c1_q <= coef_real; d1_q <= coef_imag;
            v2_q <= v1_q; sop2_q <= sop1_q; eop2_q <= eop1_q; err2_q <= err1_q; mode2_q <= mode1_q;
            for (int k = 0; k < nChan; k++) begin
                ac_q[k] <= ac_d[k]; bd_q[k] <= bd_d[k]; bc_q[k] <= bc_d[k]; ad_q[k] <= ad_d[k];
                a2_q[k] <= $signed(re1_q[k*wDataIn +: wDataIn]);
                b2_q[k] <= $signed(im1_q[k*wDataIn +: wDataIn]);
            end
            src_valid_q <= v2_q; src_sop_q <= sop2_q; src_eop_q <= eop2_q;
            src_err_q <= err2_q; src_sat_q <= sat_d; src_re_q <= out_re_d; src_im_q <= out_im_d;
        end
    end

    assign source_valid = src_valid_q;
    assign source_sop   = src_sop_q;
    assign source_eop   = src_eop_q;
    assign source_error = src_err_q;
    assign source_sat   = src_sat_q;
    assign source_real  = src_re_q;
    assign source_imag  = src_im_q;
    assign fftpts_out   = fft_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_ce_ls_mult_mc.sv
// Bench for ce_ls_mult_mc: directed arithmetic vectors, then framed random traffic against an
// arithmetic reference model with randomized backpressure.
module tb_ce_ls_mult_mc;
    localparam int WI = 16;
    localparam int WC = 18;
    localparam int WO = 16;
    localparam int NC = 2;
    localparam int SH = 16;
    localparam int EW = 5 + 2 * NC * WO;

    logic clk = 1'b0;
    logic rst_n_sync = 1'b0;
    logic sink_valid = 1'b0, sink_ready, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [NC*WI-1:0] sink_real = '0, sink_imag = '0;
    logic [WC-1:0] coef_real = '0, coef_imag = '0;
    logic [1:0] mode = '0;
    logic [11:0] fftpts_in = '0, fftpts_out;
    logic source_valid, source_ready = 1'b0, source_sop, source_eop, source_sat, dbg_state;
    logic [NC*WO-1:0] source_real, source_imag;
    logic [1:0] source_error;

    typedef struct packed {
        logic sop;
        logic eop;
        logic [1:0] mode;
        logic [11:0] fft;
        logic [NC*WI-1:0] re;
        logic [NC*WI-1:0] im;
        logic [WC-1:0] c;
        logic [WC-1:0] d;
    } beat_t;

    beat_t stim_q[$];
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;

    bit m_inframe;
    int m_cnt, m_fft;
    logic [1:0] m_mode;

    ce_ls_mult_mc #(.wDataIn(WI), .wCoeff(WC), .wDataOut(WO), .nChan(NC), .SHIFT(SH)) dut (
        .clk(clk), .rst_n_sync(rst_n_sync),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .coef_real(coef_real), .coef_imag(coef_imag),
        .mode(mode), .fftpts_in(fftpts_in),
        .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
        .source_eop(source_eop), .source_real(source_real), .source_imag(source_imag),
        .source_error(source_error), .source_sat(source_sat), .fftpts_out(fftpts_out),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint clip(input longint v, inout bit s);
        longint mx;
        mx = (longint'(1) << (WO - 1)) - 1;
        if (v > mx) begin s = 1'b1; return mx; end
        if (v < -mx - 1) begin s = 1'b1; return -mx - 1; end
        return v;
    endfunction

    function automatic logic [WC-1:0] rand_coef();
        if ($urandom_range(0, 1) == 1) return WC'($urandom);
        return WC'(int'($urandom_range(0, 131072)) - 65536);
    endfunction

    task automatic model_reset();
        m_inframe = 1'b0;
        m_cnt = 0;
        m_fft = 0;
        m_mode = 2'b00;
        exp_q.delete();
    endtask

    // Framing rules and complex arithmetic evaluated directly on integers.
    task automatic model_accept(input beat_t bt);
        logic [1:0] err;
        longint a, b, c, d, xr, xi, orr, oi;
        bit s;
        logic [NC*WO-1:0] pr, pi;
        err = 2'b00;
        s = 1'b0;
        if (bt.sop) begin
            if (m_inframe) err[1] = 1'b1;
            m_mode = bt.mode;
            m_fft = int'(bt.fft);
            m_cnt = 1;
            m_inframe = !bt.eop;
            if (bt.eop && bt.fft != 12'd1) err[1] = 1'b1;
        end else if (!m_inframe) begin
            err[0] = 1'b1;
        end else begin
            m_cnt++;
            if (bt.eop) begin
                m_inframe = 1'b0;
                if (m_cnt != m_fft) err[1] = 1'b1;
            end
        end
        c = longint'($signed(bt.c));
        d = longint'($signed(bt.d));
        for (int k = 0; k < NC; k++) begin
            a = longint'($signed(bt.re[k*WI +: WI]));
            b = longint'($signed(bt.im[k*WI +: WI]));
            if (m_mode[1]) begin
                orr = clip(a, s);
                oi = clip(b, s);
            end else begin
                if (m_mode == 2'b00) begin xr = a * c + b * d; xi = b * c - a * d; end
                else begin xr = a * c - b * d; xi = a * d + b * c; end
                orr = clip((xr + (longint'(1) << (SH - 1))) >>> SH, s);
                oi = clip((xi + (longint'(1) << (SH - 1))) >>> SH, s);
            end
            pr[k*WO +: WO] = orr[WO-1:0];
            pi[k*WO +: WO] = oi[WO-1:0];
        end
        exp_q.push_back({bt.sop, bt.eop, err, s, pr, pi});
    endtask

    task automatic add_frame(input int len, input int fft, input logic [1:0] md,
                             input bit with_sop, input bit with_eop);
        beat_t bt;
        for (int i = 0; i < len; i++) begin
            bt.sop = with_sop && (i == 0);
            bt.eop = with_eop && (i == len - 1);
            bt.mode = (i == 0) ? md : 2'($urandom_range(0, 3));
            bt.fft = (i == 0) ? 12'(fft) : 12'($urandom_range(0, 4095));
            bt.re = $urandom;
            bt.im = $urandom;
            bt.c = rand_coef();
            bt.d = rand_coef();
            stim_q.push_back(bt);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n_sync = 1'b0;
        sink_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_sync = 1'b1;
        model_reset();
    endtask

    // Drains stim_q through the DUT; stall_at >= 0 holds source_ready low for 5 cycles
    // once that many beats have left the DUT, otherwise source_ready is random.
    task automatic run_stim(input int stall_at);
        int cyc, outs, stall;
        bit pend, stalled;
        beat_t cur;
        cyc = 0; outs = 0; stall = 0; pend = 1'b0; stalled = 1'b0;
        cur = '0;
        while ((stim_q.size() > 0 || pend || exp_q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stall > 0) begin
                source_ready = 1'b0;
                stall--;
            end else if (stall_at >= 0 && outs == stall_at && !stalled) begin
                source_ready = 1'b0;
                stall = 4;
                stalled = 1'b1;
            end else if (stall_at >= 0) begin
                source_ready = 1'b1;
            end else begin
                source_ready = ($urandom_range(0, 3) != 0);
            end
            if (!pend && stim_q.size() > 0 && $urandom_range(0, 4) != 0) begin
                cur = stim_q.pop_front();
                pend = 1'b1;
            end
            sink_valid = pend;
            sink_sop = cur.sop;
            sink_eop = cur.eop;
            mode = cur.mode;
            fftpts_in = cur.fft;
            sink_real = cur.re;
            sink_imag = cur.im;
            coef_real = cur.c;
            coef_imag = cur.d;
            #1;
            check("sink_ready", EW'(sink_ready), EW'(!source_valid || source_ready));
            if (sink_valid && sink_ready) begin
                model_accept(cur);
                pend = 1'b0;
            end
            if (source_valid && source_ready) begin
                if (exp_q.size() == 0) check("spurious_out", EW'(exp_q.size()), EW'(1));
                else check("beat", {source_sop, source_eop, source_error, source_sat,
                                    source_real, source_imag}, exp_q.pop_front());
                outs++;
            end
        end
        check("drain", EW'(stim_q.size() + exp_q.size() + int'(pend)), EW'(0));
        @(negedge clk);
        sink_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [1:0] md,
                              input logic signed [WI-1:0] a0, b0, a1, b1,
                              input logic signed [WC-1:0] c, d,
                              input logic signed [WO-1:0] r0, i0, r1, i1, input logic s);
        int lat;
        @(negedge clk);
        source_ready = 1'b1;
        sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b1;
        mode = md; fftpts_in = 12'd1;
        sink_real = {a1, a0}; sink_imag = {b1, b0};
        coef_real = c; coef_imag = d;
        #1 check({tag, "_rdy"}, EW'(sink_ready), EW'(1));
        @(negedge clk);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        lat = 1;
        while (!source_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, EW'(lat), EW'(3));
        check(tag, {source_sop, source_eop, source_error, source_sat, source_real, source_imag},
              {1'b1, 1'b1, 2'b00, s, r1, r0, i1, i0});
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", EW'(source_valid), EW'(0));
        check("rst_ready", EW'(sink_ready), EW'(1));
        check("rst_outs", {source_sop, source_eop, source_error, source_sat, source_real, source_imag}, '0);
        check("rst_fft", EW'(fftpts_out), EW'(0));
        check("rst_state", EW'(dbg_state), EW'(0));
        @(negedge clk);
        rst_n_sync = 1'b1;

        run_single("unity", 2'b00, 16'sd1000, -16'sd500, -16'sd7, 16'sd3, 18'sd65536, 18'sd0,
                   16'sd1000, -16'sd500, -16'sd7, 16'sd3, 1'b0);
        run_single("conj_j", 2'b00, 16'sd1000, -16'sd500, 16'sd0, 16'sd0, 18'sd0, 18'sd65536,
                   -16'sd500, -16'sd1000, 16'sd0, 16'sd0, 1'b0);
        run_single("plain_j", 2'b01, 16'sd1000, -16'sd500, 16'sd0, 16'sd0, 18'sd0, 18'sd65536,
                   16'sd500, 16'sd1000, 16'sd0, 16'sd0, 1'b0);
        run_single("round", 2'b00, 16'sd1, -16'sd1, 16'sd3, 16'sd0, 18'sd32768, 18'sd0,
                   16'sd1, 16'sd0, 16'sd2, 16'sd0, 1'b0);
        run_single("sat", 2'b00, 16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 18'sd92682, 18'sd92682,
                   16'sd32767, 16'sd0, 16'sd0, 16'sd0, 1'b1);
        run_single("bypass", 2'b10, 16'sd1234, -16'sd4321, -16'sd32768, 16'sd32767, 18'sd5, -18'sd9,
                   16'sd1234, -16'sd4321, -16'sd32768, 16'sd32767, 1'b0);
        check("fft_latched1", EW'(fftpts_out), EW'(1));

        apply_reset();
        add_frame(12, 12, 2'b00, 1'b1, 1'b1);
        run_stim(5);
        check("fft_latched12", EW'(fftpts_out), EW'(12));

        add_frame(10, 12, 2'b01, 1'b1, 1'b1);
        add_frame(1, 12, 2'b00, 1'b0, 1'b1);
        add_frame(3, 5, 2'b00, 1'b1, 1'b0);
        add_frame(4, 4, 2'b10, 1'b1, 1'b1);
        add_frame(1, 1, 2'b01, 1'b1, 1'b1);
        run_stim(-1);

        for (int f = 0; f < 30; f++) begin
            int len, fft;
            len = $urandom_range(1, 8);
            fft = ($urandom_range(0, 2) == 0) ? len + $urandom_range(0, 1) * 2 - 1 : len;
            add_frame(len, fft, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        end
        run_stim(-1);

        @(negedge clk);
        source_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sink_valid = 1'b1; sink_sop = (i == 0); sink_eop = 1'b0;
            mode = 2'b01; fftpts_in = 12'd8;
            sink_real = $urandom; sink_imag = $urandom;
            @(negedge clk);
        end
        sink_valid = 1'b0; sink_sop = 1'b0;
        check("pre_rst_valid", EW'(source_valid), EW'(1));
        check("pre_rst_state", EW'(dbg_state), EW'(1));
        #2 rst_n_sync = 1'b0;
        #1;
        check("async_rst_valid", EW'(source_valid), EW'(0));
        check("async_rst_state", EW'(dbg_state), EW'(0));
        check("async_rst_fft", EW'(fftpts_out), EW'(0));
        check("async_rst_ready", EW'(sink_ready), EW'(1));
        @(negedge clk);
        rst_n_sync = 1'b1;
        model_reset();
        add_frame(1, 3, 2'b00, 1'b0, 1'b0);
        add_frame(3, 3, 2'b00, 1'b1, 1'b1);
        run_stim(-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ce_ls_mult_mc.md
Name: ce_ls_mult_mc

Overview:
Multi-channel least-square channel estimator for the CE chain. Each beat, it multiplies nChan received subcarrier samples by the conjugate of one shared RS-TX coefficient, then rounds, scales by 2^-SHIFT and saturates. It has full ready/valid backpressure, frame-length checking against fftpts_in, and runtime mode select. It sits between the RS subcarrier demapper and the DCT-based CE filter.

Parameters:
wDataIn, 16, signed width of each input real/imag component
wCoeff, 18, signed width of the coefficient real/imag
wDataOut, 16, signed width of each output component
nChan, 2, number of RX antenna channels processed in parallel
SHIFT, 16, right-shift applied after multiply (>=1)

Ports:
clk  in  1  clock
rst_n_sync  in  1  reset, asynchronous assert, active-low
sink_valid  in  1  input beat valid
sink_ready  out  1  input beat accepted when valid&ready
sink_sop  in  1  first beat of frame
sink_eop  in  1  last beat of frame
sink_real  in  nChan*wDataIn  channel k at bits [k*wDataIn +: wDataIn]
sink_imag  in  nChan*wDataIn  as sink_real
coef_real  in  wCoeff  RS-TX coefficient real part, same beat as sink
coef_imag  in  wCoeff  RS-TX coefficient imag part
mode  in  2  00 conj-multiply (LS), 01 plain multiply, 1x bypass
fftpts_in  in  12  expected beats per frame
source_valid  out  1  output beat valid
source_ready  in  1  downstream ready
source_sop  out  1  aligned sop
source_eop  out  1  aligned eop
source_real  out  nChan*wDataOut  packed as input
source_imag  out  nChan*wDataOut  packed as input
source_error  out  2  [0] missing sop, [1] bad length/early sop
source_sat  out  1  any channel component saturated this beat
fftpts_out  out  12  fftpts value latched at frame sop

Behaviour:
- Reset (async, rst_n_sync=0): all pipeline valids, source_* outputs, counter, FSM and latched mode/fftpts go to 0/IDLE. sink_ready=1 after reset.
- Pipeline: S1 input register, S2 products, S3 add/round/shift/saturate = output register. Latency is 3 cycles from accepted beat to source_valid when unstalled.
- Global enable en = !source_valid | source_ready. All stages advance only when en=1. sink_ready = en (combinational). Bubbles are filled because en=1 whenever output is empty. No beat is lost or duplicated. Order is preserved.
- Arithmetic, per channel, all signed, with a=re, b=im, c=coef_real, d=coef_imag:
  - mode 00: re = a*c + b*d, im = b*c - a*d
  - mode 01: re = a*c - b*d, im = a*d + b*c
  - Sum width is wDataIn+wCoeff+1.
  - Round half-up: add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - Saturate to [-2^(wDataOut-1), 2^(wDataOut-1)-1].
  - source_sat = OR of all clip events for that beat.
- mode 1x bypass: outputs = inputs sign-extended or saturated to wDataOut, no shift. Latency is unchanged.
- mode and fftpts_in are sampled on the accepted sop beat and held for the frame. Changes mid-frame are ignored. fftpts_out shows the latched value.
- Frame FSM:
  - IDLE: accepted beat with sop goes to INFRAME with cnt=1. An accepted beat without sop is still passed through with error[0]=1, state stays IDLE.
  - INFRAME: cnt increments per accepted beat.
    - eop with cnt+1==fftpts goes to IDLE, error=00.
    - eop with cnt+1!=fftpts goes to IDLE with error[1]=1 on that beat.
    - sop while INFRAME sets error[1] on that beat and restarts cnt=1.
    - sop&eop together on one beat: single-beat frame, checked against fftpts==1.
- Error bits travel with their beat through the pipeline. Data is never dropped because of an error.
- Reset mid-frame discards all in-flight beats. The next beat must carry sop.

Test Plan:
- mode 00, coef=65536+j0, chan0=1000-j500, chan1=-7+j3 -> out 1000-j500, -7+j3, 3 cycles later, error=00, sat=0.
- mode 00, coef=0+j65536, in=1000-j500 -> -500-j1000. mode 01 same inputs -> 500+j1000.
- Rounding with coef=32768+j0: in=1 -> 1, in=-1 -> 0, in=3 -> 2. Saturation with in=32767+j32767, coef=92682+j92682, mode 00 -> re=32767, im=0, source_sat=1.
- 12-beat frame, fftpts_in=12, source_ready low for 5 cycles at beat 6 -> sink_ready low during the stall, all 12 beats out in order, sop/eop on beats 1/12, error=00.
- fftpts_in=12 with eop on beat 10 -> error[1]=1 on output beat 10. Next beat without sop -> error[0]=1. Assert rst_n_sync mid-frame -> source_valid=0 immediately (asynchronous), FSM IDLE.
